// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the branch predictor slice:
//   - 2-bit saturating counter encodings and the allocation value
//   - index / tag width derivation from XLEN and ENTRIES
//   - per-entry metadata layout (valid + counter); tag and target are held in
//     parallel arrays because their widths depend on module parameters.
// Full entry layout, MSB to LSB: {valid, tag[TAGW-1:0], target[XLEN-1:0], ctr[1:0]}
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,   // strongly not taken
      WNT = 2'b01,   // weakly not taken (reset value)
      WT  = 2'b10,   // weakly taken
      ST  = 2'b11    // strongly taken
   } ctr_t;

   // A freshly allocated entry starts weakly taken.
   localparam ctr_t CTR_ALLOC = WT;
   localparam ctr_t CTR_RESET = WNT;

   // Entry metadata: valid bit and prediction counter.
   typedef struct packed {
      logic valid;
      ctr_t ctr;
   } bp_meta_t;

   // Index bits are pc[IDXW+1:2]; word-aligned PCs drop bits [1:0].
   function automatic int bp_idx_width(input int entries);
      return $clog2(entries);
   endfunction

   // Tag is everything above the index: pc[XLEN-1:IDXW+2].
   function automatic int bp_tag_width(input int xlen, input int entries);
      return xlen - $clog2(entries) - 2;
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// Next-state logic for a 2-bit saturating prediction counter.
// Ports:
//   cur   - current counter state
//   taken - resolved branch outcome
//   nxt   - next counter state (saturates at SNT and ST)
// -----------------------------------------------------------------------------
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = cur + 2'd1;
      end else begin
         if (cur != SNT) nxt = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with a 2-bit saturating counter per entry.
// Optional statistics counters are built when BRANCH_PREDICTOR_STATS_EN is
// defined.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   f_valid, f_pc     - fetch lookup request
//   p_taken, p_target - combinational prediction for f_pc
//   r_valid, r_pc, r_taken, r_target
//                     - branch resolved in execute this cycle
//   r_pred_taken, r_pred_target
//                     - prediction that travelled with the resolved branch
//   mispredict, redirect_pc
//                     - flush request and the correct next PC
//   stat_branches, stat_mispredicts (BRANCH_PREDICTOR_STATS_EN only)
//                     - wrapping counts of resolves and mispredicts
// Handshake: f_valid and r_valid are qualifiers only; there is no ready, every
// request is accepted in the cycle it is presented. Lookup reads the table as
// it stands before any update on the same edge.
// -----------------------------------------------------------------------------
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_pc,
   output logic            p_taken,
   output logic [XLEN-1:0] p_target,
   input  logic            r_valid,
   input  logic [XLEN-1:0] r_pc,
   input  logic            r_taken,
   input  logic [XLEN-1:0] r_target,
   input  logic            r_pred_taken,
   input  logic [XLEN-1:0] r_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDXW = bp_idx_width(ENTRIES);
   localparam int TAGW = bp_tag_width(XLEN, ENTRIES);

   bp_meta_t        meta_q [ENTRIES];
   logic [TAGW-1:0] tag_q  [ENTRIES];
   logic [XLEN-1:0] tgt_q  [ENTRIES];

   logic [IDXW-1:0] f_idx;
   logic [TAGW-1:0] f_tag;
   logic [IDXW-1:0] r_idx;
   logic [TAGW-1:0] r_tag;
   logic            f_hit;
   logic            r_hit;
   logic [1:0]      ctr_nxt;

   assign f_idx = f_pc[IDXW+1:2];
   assign f_tag = f_pc[XLEN-1:IDXW+2];
   assign r_idx = r_pc[IDXW+1:2];
   assign r_tag = r_pc[XLEN-1:IDXW+2];

   // ---------------- lookup ----------------
   assign f_hit    = meta_q[f_idx].valid && (tag_q[f_idx] == f_tag);
   // rst_n gating keeps the outputs quiet for the whole reset window, not just
   // once the cleared table propagates.
   assign p_taken  = rst_n && f_valid && f_hit && meta_q[f_idx].ctr[1];
   assign p_target = p_taken ? tgt_q[f_idx] : f_pc + XLEN'(4);

   // ---------------- resolve ----------------
   assign r_hit       = meta_q[r_idx].valid && (tag_q[r_idx] == r_tag);
   assign mispredict  = rst_n && r_valid &&
                        ((r_taken != r_pred_taken) ||
                         (r_taken && (r_target != r_pred_target)));
   assign redirect_pc = r_taken ? r_target : r_pc + XLEN'(4);

   bp_sat_counter u_sat_counter (
      .cur   (meta_q[r_idx].ctr),
      .taken (r_taken),
      .nxt   (ctr_nxt)
   );

   // ---------------- table update ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            meta_q[i] <= '{valid: 1'b0, ctr: CTR_RESET};
            tag_q[i]  <= '0;
            tgt_q[i]  <= '0;
         end
      end else if (r_valid) begin
         if (r_hit) begin
            meta_q[r_idx].ctr <= ctr_t'(ctr_nxt);
            if (r_taken) tgt_q[r_idx] <= r_target;
         end else if (r_taken) begin
            // Miss on a taken branch evicts whatever occupies the slot.
            meta_q[r_idx] <= '{valid: 1'b1, ctr: CTR_ALLOC};
            tag_q[r_idx]  <= r_tag;
            tgt_q[r_idx]  <= r_target;
         end
      end
   end

`ifdef BRANCH_PREDICTOR_STATS_EN
   // ---------------- statistics ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (r_valid)    stat_branches    <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Randomized and directed stimulus for branch_predictor (XLEN=32, ENTRIES=16).
// Expected lookup and resolve responses are pushed into queues by the driver
// from a table model; a monitor pops and compares on the falling edge whenever
// f_valid or r_valid is presented. Define BRANCH_PREDICTOR_STATS_EN to also
// check the statistics counters.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 16;
   localparam int IDXW    = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            f_valid;
   logic [XLEN-1:0] f_pc;
   logic            p_taken;
   logic [XLEN-1:0] p_target;
   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic            r_taken;
   logic [XLEN-1:0] r_target;
   logic            r_pred_taken;
   logic [XLEN-1:0] r_pred_target;
   logic            mispredict;
   logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;
`endif

   branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .f_valid       (f_valid),
      .f_pc          (f_pc),
      .p_taken       (p_taken),
      .p_target      (p_target),
      .r_valid       (r_valid),
      .r_pc          (r_pc),
      .r_taken       (r_taken),
      .r_target      (r_target),
      .r_pred_taken  (r_pred_taken),
      .r_pred_target (r_pred_target),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc)
`ifdef BRANCH_PREDICTOR_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [XLEN:0] exp_f_q[$];   // {p_taken, p_target}
   logic [XLEN:0] exp_r_q[$];   // {mispredict, redirect_pc}

   // ---------------- reference model ----------------
   bit              m_valid [ENTRIES];
   logic [XLEN-1:0] m_tag   [ENTRIES];
   logic [XLEN-1:0] m_tgt   [ENTRIES];
   int              m_cnt   [ENTRIES];   // 0..3, taken when >= 2
   longint          m_branches;
   longint          m_mispredicts;

   function automatic int m_idx(input logic [XLEN-1:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic logic [XLEN-1:0] m_tagof(input logic [XLEN-1:0] pc);
      return pc >> (IDXW + 2);
   endfunction

   function automatic bit m_hit(input logic [XLEN-1:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
   endfunction

   function automatic logic [XLEN:0] m_predict(input logic [XLEN-1:0] pc);
      if (m_hit(pc) && m_cnt[m_idx(pc)] >= 2) return {1'b1, m_tgt[m_idx(pc)]};
      return {1'b0, pc + 32'd4};
   endfunction

   task automatic m_clear();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_cnt[i]   = 1;
      end
      m_branches    = 0;
      m_mispredicts = 0;
   endtask

   task automatic m_update(input logic [XLEN-1:0] pc, input logic taken,
                           input logic [XLEN-1:0] tgt);
      int k;
      k = m_idx(pc);
      if (m_hit(pc)) begin
         m_cnt[k] = taken ? ((m_cnt[k] == 3) ? 3 : m_cnt[k] + 1)
                          : ((m_cnt[k] == 0) ? 0 : m_cnt[k] - 1);
         if (taken) m_tgt[k] = tgt;
      end else if (taken) begin
         m_valid[k] = 1;
         m_tag[k]   = m_tagof(pc);
         m_tgt[k]   = tgt;
         m_cnt[k]   = 2;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: sample mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (f_valid) begin
         if (exp_f_q.size() == 0) begin
            n_checks++;
            $display("FAIL lookup_underflow: no expectation at %0t", $time);
         end else begin
            check("lookup", {31'd0, p_taken, p_target}, {31'd0, exp_f_q.pop_front()});
         end
      end
      if (r_valid) begin
         if (exp_r_q.size() == 0) begin
            n_checks++;
            $display("FAIL resolve_underflow: no expectation at %0t", $time);
         end else begin
            check("resolve", {31'd0, mispredict, redirect_pc}, {31'd0, exp_r_q.pop_front()});
         end
      end
   end

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after the next one.
   task automatic drive(input logic fv, input logic [XLEN-1:0] fpc,
                        input logic rv, input logic [XLEN-1:0] rpc,
                        input logic rt, input logic [XLEN-1:0] rtgt,
                        input logic rpt, input logic [XLEN-1:0] rptgt);
      logic mp;
      logic [XLEN-1:0] redir;
      f_valid = fv;  f_pc = fpc;
      r_valid = rv;  r_pc = rpc;  r_taken = rt;  r_target = rtgt;
      r_pred_taken = rpt;  r_pred_target = rptgt;
      mp    = rst_n && rv && ((rt != rpt) || (rt && (rtgt != rptgt)));
      redir = rt ? rtgt : rpc + 32'd4;
      if (fv) exp_f_q.push_back(m_predict(fpc));
      if (rv) exp_r_q.push_back({mp, redir});
      @(posedge clk);
      if (rst_n && rv) begin
         m_update(rpc, rt, rtgt);
         m_branches++;
         if (mp) m_mispredicts++;
      end
      #1;
   endtask

   task automatic idle();
      drive(0, '0, 0, '0, 0, '0, 0, '0);
   endtask

   task automatic check_stats(input string tag);
`ifdef BRANCH_PREDICTOR_STATS_EN
      check({tag, "_branches"},    {32'd0, stat_branches},    {32'd0, 32'(m_branches)});
      check({tag, "_mispredicts"}, {32'd0, stat_mispredicts}, {32'd0, 32'(m_mispredicts)});
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Reset asserted mid-cycle with a coincident update that must be dropped.
   task automatic pulse_reset();
      rst_n = 1'b0;
      m_clear();
      drive(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
      rst_n = 1'b1;
      check_stats("stats_after_reset");
   endtask

   function automatic logic [XLEN-1:0] rand_pc();
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
   endfunction

   function automatic logic [XLEN-1:0] rand_tgt();
      case ($urandom_range(0, 3))
         0:       return 32'h80;
         1:       return 32'h200;
         2:       return 32'h3c0;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [XLEN-1:0] pc_a, pc_b, tgt;
      logic [XLEN:0]   pred;
      logic            fv, rv, rt;
      rst_n = 1'b0;
      m_clear();
      f_valid = 0; f_pc = '0; r_valid = 0; r_pc = '0; r_taken = 0;
      r_target = '0; r_pred_taken = 0; r_pred_target = '0;
      repeat (2) @(posedge clk);
      #1;
      // Lookup and resolve during reset: no prediction, no flush.
      drive(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
      rst_n = 1'b1;
      check_stats("stats_reset");

      // Cold lookup, then allocate via a mispredicted taken branch.
      drive(1, 32'h100, 0, '0, 0, '0, 0, '0);
      drive(0, '0, 1, 32'h100, 1, 32'h80, 0, 32'h104);
      drive(1, 32'h100, 0, '0, 0, '0, 0, '0);
      // Not-taken resolves walk the counter down and saturate at 00.
      drive(1, 32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80);
      drive(0, '0, 1, 32'h100, 0, 32'h0, 1, 32'h80);
      drive(1, 32'h100, 1, 32'h100, 0, 32'h0, 0, 32'h0);
      drive(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
      drive(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
      // Same index, different tag: replacement.
      drive(0, '0, 1, 32'h140, 1, 32'h300, 0, 32'h144);
      drive(1, 32'h100, 0, '0, 0, '0, 0, '0);
      drive(1, 32'h140, 0, '0, 0, '0, 0, '0);
      // Same-cycle lookup and allocate.
      drive(1, 32'h200, 1, 32'h200, 1, 32'h240, 0, 32'h204);
      drive(1, 32'h200, 1, 32'h200, 1, 32'h240, 1, 32'h240);
      drive(1, 32'hffff_fffc, 0, '0, 0, '0, 0, '0);   // wrap of pc+4
      check_stats("stats_directed");

      // Randomized traffic with a mid-run reset.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) pulse_reset();
         fv   = ($urandom_range(0, 3) != 0);
         rv   = ($urandom_range(0, 1) != 0);
         rt   = ($urandom_range(0, 1) != 0);
         pc_a = rand_pc();
         pc_b = rand_pc();
         tgt  = rand_tgt();
         if ($urandom_range(0, 1) != 0) pred = m_predict(pc_b);
         else pred = {1'($urandom_range(0, 1)), rand_tgt()};
         drive(fv, pc_a, rv, pc_b, rt, tgt, pred[XLEN], pred[XLEN-1:0]);
      end
      idle();
      check_stats("stats_final");
      idle();
      check("queue_drain", 64'(exp_f_q.size() + exp_r_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
- REQ-001 SHALL have parameter XLEN, default 32: datapath and PC width.
- REQ-002 SHALL have parameter ENTRIES, default 16: number of BTB entries; power of two, at least 2.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port f_valid, input, 1 bit: fetch lookup request.
- REQ-006 SHALL have port f_pc, input, XLEN bits: fetch PC.
- REQ-007 SHALL have port p_taken, output, 1 bit: predicted taken for f_pc.
- REQ-008 SHALL have port p_target, output, XLEN bits: predicted next PC.
- REQ-009 SHALL have port r_valid, input, 1 bit: a conditional branch resolved in execute this cycle.
- REQ-010 SHALL have port r_pc, input, XLEN bits: PC of the resolved branch.
- REQ-011 SHALL have port r_taken, input, 1 bit: actual outcome, from the branch comparator's PC-select bit.
- REQ-012 SHALL have port r_target, input, XLEN bits: actual branch target.
- REQ-013 SHALL have ports r_pred_taken (input, 1 bit) and r_pred_target (input, XLEN bits): the prediction carried down the pipeline with the branch.
- REQ-014 SHALL have port mispredict, output, 1 bit: flush request.
- REQ-015 SHALL have port redirect_pc, output, XLEN bits: correct next PC.

Function
- REQ-016 SHALL index the table with pc[IDXW+1:2] (IDXW = log2 ENTRIES) and tag with pc[XLEN-1:IDXW+2]; each entry SHALL hold valid, tag, target, and a 2-bit counter.
- REQ-017 Lookup SHALL be combinational on the current table contents.
- REQ-018 p_taken SHALL equal f_valid && entry.valid && tag match && counter[1]; otherwise p_taken SHALL be 0.
- REQ-019 p_target SHALL be entry.target when p_taken=1, else f_pc+4 (modulo 2^XLEN).
- REQ-020 On the clock edge with r_valid=1 and an r_pc hit, the counter SHALL increment if r_taken=1 and decrement otherwise, saturating at 00 and 11; the target SHALL be rewritten with r_target when r_taken=1.
- REQ-021 On an r_valid miss with r_taken=1, the entry SHALL be allocated (overwriting any occupant) with valid=1, the new tag, target=r_target, and counter=10.
- REQ-022 An r_valid miss with r_taken=0 SHALL leave the table unchanged.
- REQ-023 mispredict SHALL be combinational: r_valid && ((r_taken != r_pred_taken) || (r_taken && r_target != r_pred_target)).
- REQ-024 redirect_pc SHALL be r_target when r_taken=1, else r_pc+4.
- REQ-025 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update contents; the update SHALL take effect on the next cycle.
- REQ-026 With r_valid=0, no table state SHALL change and mispredict SHALL be 0.

Reset
- REQ-027 On rst_n=0, all entries SHALL immediately and asynchronously get valid=0 and counter=01, and tags/targets SHALL be zero.
- REQ-028 During reset, outputs SHALL be p_taken=0, p_target=f_pc+4, and mispredict=0.
- REQ-029 An update coincident with reset assertion SHALL be discarded.
- REQ-030 Table updates SHALL resume on the first rising edge after rst_n deasserts.

Configuration
- REQ-031 With BRANCH_PREDICTOR_STATS_EN defined, the block SHALL add 32-bit outputs stat_branches and stat_mispredicts.
- REQ-032 stat_branches SHALL count r_valid cycles and stat_mispredicts SHALL count mispredict cycles; both SHALL reset to 0 and wrap modulo 2^32.
- REQ-033 Without BRANCH_PREDICTOR_STATS_EN, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-034 The shared defines/package SHALL hold: counter encodings (SNT=00, WNT=01, WT=10, ST=11), the allocate value, the IDXW/tag-width derivation, and the entry field layout.
- REQ-035 Saturating-counter next-state logic SHALL be a sub-module, bp_sat_counter: current state + taken in, next state out.

Verification (ENTRIES=16)
- REQ-036 After reset, f_pc=0x100 -> p_taken=0, p_target=0x104.
- REQ-037 r_valid, r_pc=0x100, r_taken=1, r_target=0x80, r_pred_taken=0 -> mispredict=1, redirect_pc=0x80; next cycle f_pc=0x100 -> p_taken=1, p_target=0x80.
- REQ-038 Two further not-taken resolves of 0x100 -> counter 10→01→00; then lookup of 0x100 -> p_taken=0; a further not-taken resolve -> counter stays 00.
- REQ-039 Entry allocated for 0x100; taken resolve of 0x140 (same index, different tag) -> entry replaced; lookup of 0x100 -> miss, p_taken=0.
- REQ-040 Same-cycle lookup and allocate of 0x200 -> p_taken=0 that cycle, p_taken=1 the next cycle.
- REQ-041 With BRANCH_PREDICTOR_STATS_EN: 5 resolves including 2 mispredicts -> stat_branches=5, stat_mispredicts=2; rst_n pulsed mid-run -> both counters read 0.
